// File: rtl/inst_sram_ctrl.sv
// Instruction-fetch responder: turns a chip-enable + PC request into a timed
// read of the external 32-bit instruction SRAM and returns the word with a
// one-cycle valid strobe, holding the PC stage via stall_req_o meanwhile.
module inst_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       pc_i,
    input  logic              flush_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              addr_err_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [3:0]        ram_be_n_o,
    input  logic [31:0]       ram_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    // Window bounds held in 33 bits so BASE_ADDR + window cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (ADDR_W + 2));

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       inst_q;
    logic              valid_q;
    logic              addr_err_q;
    logic              flushed_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_ce_n_q;
    logic              ram_oe_n_q;
    logic              pc_legal_d;
    logic [ADDR_W-1:0] word_addr_d;

    // Decode whether the requested PC is word-aligned and inside the SRAM window.
    always_comb begin
        pc_legal_d  = (pc_i[1:0] == 2'b00) &&
                      ({1'b0, pc_i} >= WIN_LO) &&
                      ({1'b0, pc_i} <  WIN_HI);
        word_addr_d = ADDR_W'((pc_i - BASE_ADDR) >> 2);
    end

    // Fetch FSM: sample request, wait out SRAM access time, present result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            inst_q     <= 32'h0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            flushed_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_ce_n_q <= 1'b1;
            ram_oe_n_q <= 1'b1;
        end else begin
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    flushed_q <= 1'b0;
                    if (ce_i) begin
                        if (pc_legal_d) begin
                            ram_addr_q <= word_addr_d;
                            ram_ce_n_q <= 1'b0;
                            ram_oe_n_q <= 1'b0;
                            cnt_q      <= 4'(WAIT_CYCLES);
                            state_q    <= ACCESS;
                        end else begin
                            addr_err_q <= 1'b1;
                            inst_q     <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    // A flush seen at any point of the access kills the strobe,
                    // but the SRAM cycle itself is always allowed to finish.
                    flushed_q <= flushed_q | flush_i;
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        inst_q     <= ram_data_i;
                        ram_ce_n_q <= 1'b1;
                        ram_oe_n_q <= 1'b1;
                        valid_q    <= ~(flushed_q | flush_i);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Hold the PC while a legal request is being accepted or an access runs.
    always_comb begin
        stall_req_o = (state_q == ACCESS) ||
                      ((state_q == IDLE) && ce_i && pc_legal_d);
    end

    // A flush arriving in the DONE cycle still has to cancel the strobe.
    assign inst_valid_o = valid_q & ~flush_i;
    assign inst_o       = inst_q;
    assign addr_err_o   = addr_err_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_ce_n_o   = ram_ce_n_q;
    assign ram_oe_n_o   = ram_oe_n_q;
    assign ram_we_n_o   = 1'b1;
    assign ram_be_n_o   = {4{ram_ce_n_q}};

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Bench for inst_sram_ctrl: one instance with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=0, each fed by a behavioural SRAM; fetched words are checked
// against a scoreboard queue filled when each request is issued.
module tb_inst_sram_ctrl;

    logic clk;
    logic rst_n;

    logic        ce, flush;
    logic [31:0] pc;
    logic [31:0] inst, rdata;
    logic        vld, aerr, stall, rce_n, roe_n, rwe_n;
    logic [19:0] raddr;
    logic [3:0]  rbe_n;

    logic        ce0, flush0;
    logic [31:0] pc0;
    logic [31:0] inst0, rdata0;
    logic        vld0, aerr0, stall0, rce_n0, roe_n0, rwe_n0;
    logic [19:0] raddr0;
    logic [3:0]  rbe_n0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_q0[$];

    function automatic logic [31:0] sram_word(input logic [19:0] a);
        return (a == 20'd0) ? 32'h3C011234 : {12'h5A5, a};
    endfunction

    assign rdata  = roe_n  ? 32'hxxxxxxxx : sram_word(raddr);
    assign rdata0 = roe_n0 ? 32'hxxxxxxxx : sram_word(raddr0);

    inst_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'h80000000), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst_n), .ce_i(ce), .pc_i(pc), .flush_i(flush),
        .inst_o(inst), .inst_valid_o(vld), .addr_err_o(aerr), .stall_req_o(stall),
        .ram_addr_o(raddr), .ram_ce_n_o(rce_n), .ram_oe_n_o(roe_n),
        .ram_we_n_o(rwe_n), .ram_be_n_o(rbe_n), .ram_data_i(rdata)
    );

    inst_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'h80000000), .ADDR_W(20)) dut0 (
        .clk(clk), .rst(rst_n), .ce_i(ce0), .pc_i(pc0), .flush_i(flush0),
        .inst_o(inst0), .inst_valid_o(vld0), .addr_err_o(aerr0), .stall_req_o(stall0),
        .ram_addr_o(raddr0), .ram_ce_n_o(rce_n0), .ram_oe_n_o(roe_n0),
        .ram_we_n_o(rwe_n0), .ram_be_n_o(rbe_n0), .ram_data_i(rdata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_strobe: inst_o=%h with no request outstanding", inst);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst !== e) begin
                    errors++;
                    $display("FAIL sb_data: inst_o=%h expected %h", inst, e);
                end
            end
        end
        if (rst_n && vld0) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_unexpected_strobe: inst_o=%h with no request outstanding", inst0);
            end else begin
                logic [31:0] e0;
                e0 = exp_q0.pop_front();
                if (inst0 !== e0) begin
                    errors++;
                    $display("FAIL sb0_data: inst_o=%h expected %h", inst0, e0);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (inst !== 32'h0)     begin errors++; $display("FAIL rst_inst: got %h want 0", inst); end
        checks++; if (vld !== 1'b0)       begin errors++; $display("FAIL rst_valid: got %b want 0", vld); end
        checks++; if (aerr !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b want 0", aerr); end
        checks++; if (raddr !== 20'h0)    begin errors++; $display("FAIL rst_addr: got %h want 0", raddr); end
        checks++; if (rce_n !== 1'b1)     begin errors++; $display("FAIL rst_ce_n: got %b want 1", rce_n); end
        checks++; if (roe_n !== 1'b1)     begin errors++; $display("FAIL rst_oe_n: got %b want 1", roe_n); end
        checks++; if (rwe_n !== 1'b1)     begin errors++; $display("FAIL rst_we_n: got %b want 1", rwe_n); end
        checks++; if (rbe_n !== 4'b1111)  begin errors++; $display("FAIL rst_be_n: got %b want 1111", rbe_n); end
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (rce_n0 !== 1'b1)    begin errors++; $display("FAIL rst0_ce_n: got %b want 1", rce_n0); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Single fetch with per-cycle check of SRAM strobes, stall and valid.
    task automatic test_single();
        @(posedge clk); #1;
        ce = 1'b1; pc = 32'h80000000;
        exp_q.push_back(32'h3C011234);
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL single_stall_req: got %b want 1", stall); end
        @(posedge clk); #1;
        ce = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (rce_n !== (k >= 3)) begin errors++; $display("FAIL single_ce_n k=%0d: got %b want %b", k, rce_n, (k >= 3)); end
            checks++; if (stall !== (k <= 2)) begin errors++; $display("FAIL single_stall k=%0d: got %b want %b", k, stall, (k <= 2)); end
            checks++; if (vld !== (k == 3))   begin errors++; $display("FAIL single_valid k=%0d: got %b want %b", k, vld, (k == 3)); end
            if (k <= 2) begin
                checks++; if (raddr !== 20'h0) begin errors++; $display("FAIL single_addr: got %h want 0", raddr); end
                checks++; if (rbe_n !== 4'b0000) begin errors++; $display("FAIL single_be_n: got %b want 0000", rbe_n); end
            end
            if (k == 4) begin
                checks++; if (inst !== 32'h3C011234) begin errors++; $display("FAIL single_hold: got %h want 3c011234", inst); end
            end
        end
    endtask

    // Generic bounded fetch on the WAIT_CYCLES=1 instance.
    task automatic run_fetch(input logic [31:0] p, input logic [19:0] wa);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        ce = 1'b1; pc = p;
        exp_q.push_back(sram_word(wa));
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_req pc=%h: got %b want 1", p, stall); end
        @(posedge clk); #1;
        ce = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (rce_n === 1'b0) begin
                checks++; if (raddr !== wa) begin errors++; $display("FAIL fetch_addr pc=%h: got %h want %h", p, raddr, wa); end
            end
            if (vld === 1'b1) begin
                got = 1'b1;
                checks++; if (k != 3) begin errors++; $display("FAIL fetch_latency pc=%h: got %0d want 3", p, k); end
            end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL fetch_timeout pc=%h: no strobe, want 1", p); end
    endtask

    // Three fetches, PC held while stalled and advanced on each strobe.
    task automatic test_sequential();
        int strobes;
        int last;
        strobes = 0;
        last = -1;
        @(posedge clk); #1;
        ce = 1'b1; pc = 32'h80000000;
        exp_q.push_back(sram_word(20'd0));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rce_n === 1'b0 && strobes < 3) begin
                checks++; if (raddr !== 20'(strobes)) begin errors++; $display("FAIL seq_addr: got %h want %h", raddr, 20'(strobes)); end
            end
            if (vld === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (c - last != 4) begin errors++; $display("FAIL seq_spacing: got %0d want 4", c - last); end
                end
                last = c;
                strobes++;
                if (strobes < 3) begin
                    pc = pc + 32'd4;
                    exp_q.push_back(sram_word(20'(strobes)));
                end else begin
                    ce = 1'b0;
                end
            end
        end
        checks++; if (strobes != 3) begin errors++; $display("FAIL seq_count: got %0d want 3", strobes); end
    endtask

    task automatic test_addr_err();
        logic [31:0] bad [2];
        bad[0] = 32'h80000002;
        bad[1] = 32'h7FFFFFFC;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            ce = 1'b1; pc = bad[i];
            @(negedge clk);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL err_stall pc=%h: got %b want 0", bad[i], stall); end
            @(posedge clk); #1;
            ce = 1'b0;
            @(negedge clk);
            checks++; if (aerr !== 1'b1)   begin errors++; $display("FAIL err_pulse pc=%h: got %b want 1", bad[i], aerr); end
            checks++; if (inst !== 32'h0)  begin errors++; $display("FAIL err_nop pc=%h: got %h want 0", bad[i], inst); end
            checks++; if (rce_n !== 1'b1)  begin errors++; $display("FAIL err_ce_n pc=%h: got %b want 1", bad[i], rce_n); end
            checks++; if (vld !== 1'b0)    begin errors++; $display("FAIL err_valid pc=%h: got %b want 0", bad[i], vld); end
            @(negedge clk);
            checks++; if (aerr !== 1'b0)   begin errors++; $display("FAIL err_width pc=%h: got %b want 0", bad[i], aerr); end
        end
    endtask

    task automatic test_flush();
        // Flush during ACCESS: read completes, strobe is dropped.
        @(posedge clk); #1;
        ce = 1'b1; pc = 32'h80000010;
        @(posedge clk); #1;
        ce = 1'b0;
        @(negedge clk);
        checks++; if (raddr !== 20'd4) begin errors++; $display("FAIL flush_addr: got %h want 4", raddr); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++; if (vld !== 1'b0)             begin errors++; $display("FAIL flush_access_valid: got %b want 0", vld); end
        checks++; if (inst !== sram_word(20'd4)) begin errors++; $display("FAIL flush_access_data: got %h want %h", inst, sram_word(20'd4)); end
        // Flush during DONE: strobe is dropped in that same cycle.
        @(posedge clk); #1;
        ce = 1'b1; pc = 32'h80000100;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (vld !== 1'b0)               begin errors++; $display("FAIL flush_done_valid: got %b want 0", vld); end
        checks++; if (inst !== sram_word(20'd64)) begin errors++; $display("FAIL flush_done_data: got %h want %h", inst, sram_word(20'd64)); end
        @(posedge clk); #1;
        flush = 1'b0;
        run_fetch(32'h80000100, 20'd64);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        ce = 1'b1; pc = 32'h80000020;
        @(posedge clk); #1;
        ce = 1'b0;
        @(negedge clk);
        checks++; if (rce_n !== 1'b0) begin errors++; $display("FAIL rmid_inflight: got %b want 0", rce_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rce_n !== 1'b1)    begin errors++; $display("FAIL rmid_ce_n: got %b want 1", rce_n); end
        checks++; if (roe_n !== 1'b1)    begin errors++; $display("FAIL rmid_oe_n: got %b want 1", roe_n); end
        checks++; if (raddr !== 20'h0)   begin errors++; $display("FAIL rmid_addr: got %h want 0", raddr); end
        checks++; if (rbe_n !== 4'b1111) begin errors++; $display("FAIL rmid_be_n: got %b want 1111", rbe_n); end
        checks++; if (inst !== 32'h0)    begin errors++; $display("FAIL rmid_inst: got %h want 0", inst); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL rmid_stall: got %b want 0", stall); end
        checks++; if (rwe_n !== 1'b1)    begin errors++; $display("FAIL rmid_we_n: got %b want 1", rwe_n); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rmid_no_strobe k=%0d: got %b want 0", k, vld); end
        end
        run_fetch(32'h80000008, 20'd2);
    endtask

    task automatic test_wait0();
        @(posedge clk); #1;
        ce0 = 1'b1; pc0 = 32'h803FFFFC;
        exp_q0.push_back(sram_word(20'hFFFFF));
        @(posedge clk); #1;
        ce0 = 1'b0;
        @(negedge clk);
        checks++; if (rce_n0 !== 1'b0)      begin errors++; $display("FAIL w0_ce_n: got %b want 0", rce_n0); end
        checks++; if (raddr0 !== 20'hFFFFF) begin errors++; $display("FAIL w0_addr: got %h want fffff", raddr0); end
        checks++; if (stall0 !== 1'b1)      begin errors++; $display("FAIL w0_stall: got %b want 1", stall0); end
        checks++; if (vld0 !== 1'b0)        begin errors++; $display("FAIL w0_early: got %b want 0", vld0); end
        @(negedge clk);
        checks++; if (vld0 !== 1'b1)        begin errors++; $display("FAIL w0_strobe: got %b want 1", vld0); end
        checks++; if (rce_n0 !== 1'b1)      begin errors++; $display("FAIL w0_release: got %b want 1", rce_n0); end
        @(negedge clk);
        checks++; if (vld0 !== 1'b0)        begin errors++; $display("FAIL w0_one_cycle: got %b want 0", vld0); end
        @(posedge clk); #1;
        ce0 = 1'b1; pc0 = 32'h80400000;
        @(negedge clk);
        checks++; if (stall0 !== 1'b0)      begin errors++; $display("FAIL w0_err_stall: got %b want 0", stall0); end
        @(posedge clk); #1;
        ce0 = 1'b0;
        @(negedge clk);
        checks++; if (aerr0 !== 1'b1)       begin errors++; $display("FAIL w0_err_pulse: got %b want 1", aerr0); end
        checks++; if (rce_n0 !== 1'b1)      begin errors++; $display("FAIL w0_err_ce_n: got %b want 1", rce_n0); end
        @(negedge clk);
        checks++; if (aerr0 !== 1'b0)       begin errors++; $display("FAIL w0_err_width: got %b want 0", aerr0); end
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b0; pc = 32'h0; flush = 1'b0;
        ce0 = 1'b0; pc0 = 32'h0; flush0 = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_sequential();
        test_addr_err();
        test_flush();
        test_reset_mid();
        test_wait0();
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        checks++; if (exp_q0.size() != 0) begin errors++; $display("FAIL sb0_leftover: got %0d want 0", exp_q0.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
